// File: rtl/rsa_pkg.sv
// rsa_pkg: shared state encoding and default widths for the RSA precompute datapath.
`default_nettype none

package rsa_pkg;

    localparam int RSA_NBITS = 1024;
    localparam int RSA_WORD  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CHK  = 2'd2,
        ST_DONE = 2'd3
    } precomp_state_t;

endpackage

`default_nettype wire

// File: rtl/mod_double_step.sv
// mod_double_step: combinational modular doubling, o_dbl = (2*x) mod n for x < n.
`default_nettype none

module mod_double_step #(
    parameter int NBITS = 1024
) (
    input  logic [NBITS-1:0] x,
    input  logic [NBITS-1:0] n,
    output logic [NBITS-1:0] o_dbl
);

    logic [NBITS:0] w_dbl;
    logic [NBITS:0] w_sub;

    assign w_dbl = {x, 1'b0};
    assign w_sub = w_dbl - {1'b0, n};

    // A borrow out of the top bit means 2x < n, so keep the plain double.
    assign o_dbl = w_sub[NBITS] ? w_dbl[NBITS-1:0] : w_sub[NBITS-1:0];

endmodule

`default_nettype wire

// File: rtl/rsa_precompute.sv
// rsa_precompute: sequencer producing n0p = -n^-1 mod 2^WORD, r = 2^NBITS mod n, t = 2^(2*NBITS) mod n.
// Optional one-cycle self-check state enabled by defining RSA_PRECOMP_CHECK_EN.
`default_nettype none

module rsa_precompute
    import rsa_pkg::*;
#(
    parameter int NBITS = RSA_NBITS,
    parameter int WORD  = RSA_WORD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NBITS-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WORD-1:0]  n0p,
    output logic [NBITS-1:0] r,
    output logic [NBITS-1:0] t
);

    localparam int CW = $clog2(2 * NBITS);

    localparam logic [CW-1:0]    c_r_last  = CW'(NBITS - 1);
    localparam logic [CW-1:0]    c_t_last  = CW'(2 * NBITS - 1);
    localparam logic [CW-1:0]    c_word    = CW'(WORD);
    localparam logic [CW-1:0]    c_cnt_one = CW'(1);
    localparam logic [NBITS-1:0] c_one     = {{(NBITS-1){1'b0}}, 1'b1};
    localparam logic [WORD-1:0]  c_w_one   = {{(WORD-1){1'b0}}, 1'b1};

    precomp_state_t r_state;
    precomp_state_t w_next;

    logic [NBITS-1:0] r_n;
    logic [NBITS-1:0] r_x;
    logic [CW-1:0]    r_cnt;
    logic [WORD-1:0]  r_s;

    logic [NBITS-1:0] w_dbl;
    logic [WORD-1:0]  w_s_add;
    logic             w_bad_n;
    logic             w_inv_phase;

    mod_double_step #(
        .NBITS (NBITS)
    ) u_dbl (
        .x     (r_x),
        .n     (r_n),
        .o_dbl (w_dbl)
    );

    assign w_bad_n     = !n[0] || (n == c_one);
    assign w_inv_phase = (r_cnt < c_word);

    // (s + n) >> 1 split as halves plus the carry of the two LSBs, so no bit is dropped.
    assign w_s_add = {1'b0, r_s[WORD-1:1]} + {1'b0, r_n[WORD-1:1]}
                   + {{(WORD-1){1'b0}}, (r_s[0] & r_n[0])};

`ifdef RSA_PRECOMP_CHECK_EN
    logic [WORD-1:0] w_chk_prod;
    logic            w_chk_ok;

    assign w_chk_prod = (r_n[WORD-1:0] * n0p) + c_w_one;
    assign w_chk_ok   = (w_chk_prod == '0) && (r < r_n) && (t < r_n);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = w_bad_n ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == c_t_last) begin
`ifdef RSA_PRECOMP_CHECK_EN
                    w_next = ST_CHK;
`else
                    w_next = ST_DONE;
`endif
                end
            end
            ST_CHK:  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n   <= '0;
            r_x   <= '0;
            r_cnt <= '0;
            r_s   <= '0;
            err   <= 1'b0;
            n0p   <= '0;
            r     <= '0;
            t     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_n   <= n;
                        r_x   <= c_one;
                        r_cnt <= '0;
                        r_s   <= c_w_one;
                        err   <= w_bad_n;
                        n0p   <= '0;
                        r     <= '0;
                        t     <= '0;
                    end
                end
                ST_RUN: begin
                    r_x   <= w_dbl;
                    r_cnt <= r_cnt + c_cnt_one;
                    // n0p fills from the top; after WORD shifts bit i sits at index i.
                    if (w_inv_phase) begin
                        r_s <= r_s[0] ? w_s_add : {1'b0, r_s[WORD-1:1]};
                        n0p <= {r_s[0], n0p[WORD-1:1]};
                    end
                    if (r_cnt == c_r_last) begin
                        r <= w_dbl;
                    end
                    if (r_cnt == c_t_last) begin
                        t <= w_dbl;
                    end
                end
`ifdef RSA_PRECOMP_CHECK_EN
                ST_CHK: begin
                    if (!w_chk_ok) begin
                        err <= 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rsa_precompute.sv
// tb_rsa_precompute: directed scoreboard bench for an 8-bit and a 1024-bit rsa_precompute instance.
`default_nettype none

module tb_rsa_precompute;

`ifdef RSA_PRECOMP_CHECK_EN
    localparam int LAT8  = 18;
    localparam int LAT1K = 2050;
`else
    localparam int LAT8  = 17;
    localparam int LAT1K = 2049;
`endif

    typedef struct {
        logic [7:0] n0p;
        logic [7:0] r;
        logic [7:0] t;
        logic       err;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          start8, busy8, done8, err8;
    logic [7:0]    n8, n0p8, r8, t8;
    logic          start1k, busy1k, done1k, err1k;
    logic [1023:0] n1k, r1k, t1k;
    logic [31:0]   n0p1k;

    rsa_precompute #(.NBITS(8), .WORD(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .n(n8),
        .busy(busy8), .done(done8), .err(err8), .n0p(n0p8), .r(r8), .t(t8)
    );

    rsa_precompute #(.NBITS(1024), .WORD(32)) u_dut1k (
        .clk(clk), .rst_n(rst_n), .start(start1k), .n(n1k),
        .busy(busy1k), .done(done1k), .err(err1k), .n0p(n0p1k), .r(r1k), .t(t1k)
    );

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (low 128 bits)", tag, obs[127:0], expv[127:0]);
        end
    endtask

    function automatic exp_t model(input logic [7:0] nv);
        exp_t e;
        int   nn;
        nn    = int'(nv);
        e.n0p = '0;
        e.r   = '0;
        e.t   = '0;
        e.err = 1'b1;
        if (nn % 2 == 1 && nn > 1) begin
            e.err = 1'b0;
            e.r   = 8'(256 % nn);
            e.t   = 8'(65536 % nn);
            for (int m = 0; m < 256; m++) begin
                if ((nn * m + 1) % 256 == 0) e.n0p = 8'(m);
            end
        end
        return e;
    endfunction

    task automatic run8(input logic [7:0] nv, input int pulse_at, input bit pulse_done);
        exp_t e;
        int   c, bc, dc, lat_exp;
        e = model(nv);
        sbq.push_back(e);
        lat_exp = e.err ? 1 : LAT8;
        n8 = nv;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        c = 1; bc = 0; dc = 0;
        while (c <= 60) begin
            if (busy8) bc++;
            if (done8) begin
                dc++;
                break;
            end
            start8 = (c == pulse_at);
            if (c == pulse_at) n8 = 8'd13;
            @(negedge clk);
            c++;
        end
        start8 = 1'b0;
        chk("latency", 1024'(c), 1024'(lat_exp));
        chk("busy_cycles", 1024'(bc), 1024'(lat_exp));
        e = sbq.pop_front();
        chk("err", 1024'(err8), 1024'(e.err));
        chk("n0p", 1024'(n0p8), 1024'(e.n0p));
        chk("r", 1024'(r8), 1024'(e.r));
        chk("t", 1024'(t8), 1024'(e.t));
        if (pulse_done) begin
            start8 = 1'b1;
            n8 = 8'd13;
        end
        @(negedge clk);
        start8 = 1'b0;
        chk("busy_after_done", 1024'(busy8), 1024'(0));
        for (int k = 0; k < 4; k++) begin
            if (done8) dc++;
            @(negedge clk);
        end
        chk("done_pulses", 1024'(dc), 1024'(1));
        if (pulse_done) begin
            chk("r_held", 1024'(r8), 1024'(e.r));
            chk("t_held", 1024'(t8), 1024'(e.t));
        end
    endtask

    initial begin
        logic [1023:0] top, exp_r;
        int c;
        rst_n = 1'b0;
        start8 = 1'b0; n8 = '0;
        start1k = 1'b0; n1k = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 1024'(busy8), 1024'(0));
        chk("rst_done", 1024'(done8), 1024'(0));
        chk("rst_err", 1024'(err8), 1024'(0));
        chk("rst_n0p", 1024'(n0p8), 1024'(0));
        chk("rst_r", 1024'(r8), 1024'(0));
        chk("rst_t", 1024'(t8), 1024'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run8(8'd187, 0, 1'b0);
        run8(8'd251, 0, 1'b0);
        run8(8'd3, 0, 1'b0);
        run8(8'd255, 0, 1'b0);
        run8(8'd186, 0, 1'b0);
        run8(8'd1, 0, 1'b0);
        run8(8'd0, 0, 1'b0);
        run8(8'd129, 5, 1'b1);
        run8(8'd187, 0, 1'b1);

        // Reset in the middle of a run.
        n8 = 8'd187;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 1024'(busy8), 1024'(0));
        chk("midrst_done", 1024'(done8), 1024'(0));
        chk("midrst_err", 1024'(err8), 1024'(0));
        chk("midrst_n0p", 1024'(n0p8), 1024'(0));
        chk("midrst_r", 1024'(r8), 1024'(0));
        chk("midrst_t", 1024'(t8), 1024'(0));
        @(negedge clk);
        rst_n = 1'b1;
        c = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done8 || busy8) c++;
        end
        chk("midrst_quiet", 1024'(c), 1024'(0));
        run8(8'd187, 0, 1'b0);

`ifdef RSA_PRECOMP_CHECK_EN
        n8 = 8'd187;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (11) @(negedge clk);
        force u_dut8.n0p = 8'h00;
        c = 12;
        while (c <= 60 && !done8) begin
            @(negedge clk);
            c++;
        end
        chk("chk_latency", 1024'(c), 1024'(LAT8));
        chk("chk_err", 1024'(err8), 1024'(1));
        release u_dut8.n0p;
        @(negedge clk);
        run8(8'd187, 0, 1'b0);
`endif

        // 1024-bit: n = 2^1023+1 gives r = n-2 = 2^1023-1 and t = (-2)^2 = 4.
        top = '0;
        top[1023] = 1'b1;
        exp_r = top - 1024'(1);
        n1k = top | 1024'(1);
        start1k = 1'b1;
        @(negedge clk);
        start1k = 1'b0;
        c = 1;
        while (c <= 3000 && !done1k) begin
            @(negedge clk);
            c++;
        end
        chk("1k_latency", 1024'(c), 1024'(LAT1K));
        chk("1k_err", 1024'(err1k), 1024'(0));
        chk("1k_n0p", 1024'(n0p1k), 1024'(32'hFFFF_FFFF));
        chk("1k_r", r1k, exp_r);
        chk("1k_t", t1k, 1024'(4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rsa_precompute.md
# rsa_precompute

Parametrised Montgomery-constant precompute engine for the RSA decryption datapath. It accepts a modulus `n` on a start pulse and produces three constants for the Montgomery multiplier: the word inverse `n0p = -n^-1 mod 2^WORD`, `r = 2^NBITS mod n` and `t = 2^(2*NBITS) mod n`. It replaces the fixed-1024-bit secondary-input top level with one sequencer that has a single start/done handshake, odd-modulus error reporting and a configurable self-check.

## Interface
- `NBITS`, 1024: modulus width in bits. Must be at least 4.
- `WORD`, 32: word width used by `n0p`. Must be at least 2 and no greater than `NBITS`.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request pulse. It is sampled only in IDLE.
- `n` in NBITS: modulus. It is sampled on the edge that accepts `start`.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when the results are valid.
- `err` out 1: set with `done` when the run failed. Held until the next accepted `start`.
- `n0p` out WORD: `-n^-1 mod 2^WORD`.
- `r` out NBITS: `2^NBITS mod n`.
- `t` out NBITS: `2^(2*NBITS) mod n`.

## Operation
- States are IDLE, RUN, CHK (present only when the check is compiled in) and DONE.
- IDLE to RUN: on `start=1`, latch `n`. Clear `err`, `n0p`, `r` and `t`. Set accumulator `x=1`, counter `cnt=0`, inverse shift register `s=1`.
- Error check at accept time: if `n[0]=0` or `n<=1`, go directly to DONE with `err=1` and all results 0.
- RUN, modular doubling, once per cycle:
  - `x <= (2x >= n) ? 2x-n : 2x`, computed with NBITS+1-bit arithmetic.
  - The invariant `x < n` always holds.
  - When `cnt == NBITS-1`, load `r` with the updated `x`.
  - When `cnt == 2*NBITS-1`, load `t` with the updated `x` and go to CHK or DONE.
- RUN, n0p bit-serial inversion, for the first WORD cycles only (`cnt < WORD`):
  - If `s[0]=1`: `s <= (s + n[WORD-1:0]) >> 1` using a WORD+1-bit add, and set `n0p[cnt]=1`.
  - Otherwise: `s <= s >> 1` and set `n0p[cnt]=0`.
- DONE: `done=1` for exactly one cycle, then go to IDLE unconditionally. `start` asserted during DONE is ignored.
- Outputs hold their values from DONE until the next accepted `start`.
- `start` asserted during RUN or CHK is ignored. There is no queueing.
- If reset asserts mid-run, the block returns to IDLE and all outputs go to 0 immediately; no `done` is produced.

## Timing
- All outputs reset to 0 (`busy`, `done`, `err`, `n0p`, `r`, `t`).
- Let `start` be accepted at edge 0.
  - Doubling updates occur at edges 1 through 2*NBITS.
  - `r` is valid after edge NBITS, but is only guaranteed to the consumer once `done` asserts.
  - `done` is high in the cycle after edge 2*NBITS, giving a latency of 2*NBITS+1 cycles.
  - With the check compiled in, CHK adds one cycle (latency 2*NBITS+2).
- Error path: `done` and `err` are high in the cycle after edge 0.
- `busy` rises in the cycle after the accept edge and falls together with `done`.
- Back-to-back runs: the earliest next accept is the first IDLE cycle after DONE.

## Configuration
- `RSA_PRECOMP_CHECK_EN` defined: adds the one-cycle CHK state, which requires both of the following:
  - `(n[WORD-1:0]*n0p + 1) mod 2^WORD == 0`
  - `r < n` and `t < n`
  - On any failure: `err=1` and results are retained for debug.
- `RSA_PRECOMP_CHECK_EN` undefined: no CHK state, no multiplier, and `err` reports only the odd-modulus and `n<=1` check.

## Structure
- Shared package `rsa_pkg`:
  - State enum `precomp_state_t`.
  - Default width constants `RSA_NBITS=1024` and `RSA_WORD=32`.
- Sub-module `mod_double_step`:
  - Combinational, parametrised by NBITS.
  - Inputs `x` and `n`; output `(2x) mod n`.
  - Reused later by the exponentiation unit.
- The top level holds only the FSM, counter, inversion shift register and output registers.

## Test plan
- `NBITS=8`, `WORD=8`, `n=187`, start pulse -> after 17 cycles `done=1`, `err=0`, `r=69`, `t=86`, `n0p=141`; `busy` is high for exactly 17 cycles.
- `NBITS=1024`, `n=2^1023+1` -> `r=2^1023-1`, `n0p=0xFFFFFFFF`, `t` matches the reference model; `done` arrives at cycle 2049 (2050 with the check enabled).
- `n=186` (even), then `n=1` -> `done` and `err` high one cycle after accept; `r=t=n0p=0`.
- `start` re-pulsed mid-RUN and during DONE -> ignored; the single result is unchanged and `done` pulses exactly once.
- `rst_n` asserted low at cycle 5 of a run -> all outputs 0 asynchronously; a new start after release gives correct results.
- With `RSA_PRECOMP_CHECK_EN` defined, force `n0p` corrupt via testbench `force` before CHK -> `err=1` with `done`.
